fp_argsel_stream: RTL and testbench



---
 rtl/fp_argsel_stream.sv | 204 ++++++++++++++++++++
 tb/tb_fp_argsel_stream.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_argsel_stream.sv
// fp_argsel_stream: streaming arg-max / arg-min selector for IEEE-754 single-precision values.
//
// A start pulse opens a frame. The block then accepts FRAME_LEN (value, index) pairs over the
// in_valid/in_ready handshake. One cycle after the last accept, it presents the index and value
// of the largest (mode=0) or smallest (mode=1) non-NaN sample. The result holds until the
// consumer takes it with out_ready.
//
// Ports:
//   clk, reset_n        clock (rising edge) and asynchronous active-low reset
//   start, mode         frame-open pulse (only honoured when idle); mode is sampled on start
//   in_valid, in_ready  sample handshake; dataa / index_in carry the sample
//   out_valid, out_ready result handshake; index_out / data_out / none_found carry the result
//   busy                high while a frame is being accumulated or a result is pending
//
// Optional feature (macro FP_ARGSEL_SECOND_EN): adds index2_out / second_valid, which report
// the runner-up sample of the frame.

module fp_argsel_stream #(
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned FRAME_LEN = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      dataa,
    input  logic [IDX_W-1:0] index_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] index_out,
    output logic [31:0]      data_out,
    output logic             none_found,
    output logic             busy
`ifdef FP_ARGSEL_SECOND_EN
    ,
    output logic [IDX_W-1:0] index2_out,
    output logic             second_valid
`endif
);

    localparam int unsigned CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             have_best_q, have_best_d;
    logic [31:0]      best_data_q, best_data_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;

    // Map a float onto an unsigned key whose integer order matches numeric order.
    // -0.0 sorts just below +0.0.
    function automatic logic [31:0] sort_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    logic [31:0] key_in, key_best;
    logic        in_nan, beats_best;

    always_comb begin
        key_in     = sort_key(dataa);
        key_best   = sort_key(best_data_q);
        in_nan     = is_nan(dataa);
        beats_best = mode_q ? (key_in < key_best) : (key_in > key_best);
    end

`ifdef FP_ARGSEL_SECOND_EN
    logic             have_second_q, have_second_d;
    logic [31:0]      second_data_q, second_data_d;
    logic [IDX_W-1:0] second_idx_q, second_idx_d;
    logic [31:0]      key_second;
    logic             beats_second;

    always_comb begin
        key_second   = sort_key(second_data_q);
        beats_second = mode_q ? (key_in < key_second) : (key_in > key_second);
    end
`endif

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        have_best_d = have_best_q;
        best_data_d = best_data_q;
        best_idx_d  = best_idx_q;
`ifdef FP_ARGSEL_SECOND_EN
        have_second_d = have_second_q;
        second_data_d = second_data_q;
        second_idx_d  = second_idx_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d      = mode;
                    cnt_d       = '0;
                    have_best_d = 1'b0;
`ifdef FP_ARGSEL_SECOND_EN
                    have_second_d = 1'b0;
`endif
                    state_d     = StAccum;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    // NaNs consume a frame slot but never become candidates.
                    if (!in_nan) begin
                        if (!have_best_q || beats_best) begin
`ifdef FP_ARGSEL_SECOND_EN
                            // A displaced best drops to runner-up.
                            if (have_best_q) begin
                                have_second_d = 1'b1;
                                second_data_d = best_data_q;
                                second_idx_d  = best_idx_q;
                            end
`endif
                            have_best_d = 1'b1;
                            best_data_d = dataa;
                            best_idx_d  = index_in;
                        end
`ifdef FP_ARGSEL_SECOND_EN
                        else if (!have_second_q || beats_second) begin
                            have_second_d = 1'b1;
                            second_data_d = dataa;
                            second_idx_d  = index_in;
                        end
`endif
                    end
                    if (cnt_q == LAST) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // start here is deliberately ignored, even alongside the handshake.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            have_best_q <= 1'b0;
            best_data_q <= '0;
            best_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            have_best_q <= have_best_d;
            best_data_q <= best_data_d;
            best_idx_q  <= best_idx_d;
        end
    end

`ifdef FP_ARGSEL_SECOND_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            have_second_q <= 1'b0;
            second_data_q <= '0;
            second_idx_q  <= '0;
        end else begin
            have_second_q <= have_second_d;
            second_data_q <= second_data_d;
            second_idx_q  <= second_idx_d;
        end
    end
`endif

    // Result outputs are forced to zero outside DONE so they read 0 after reset.
    always_comb begin
        in_ready   = (state_q == StAccum);
        out_valid  = (state_q == StDone);
        busy       = (state_q != StIdle);
        none_found = out_valid && !have_best_q;
        index_out  = (out_valid && have_best_q) ? best_idx_q : '0;
        if (!out_valid) begin
            data_out = '0;
        end else begin
            data_out = have_best_q ? best_data_q : QNAN;
        end
`ifdef FP_ARGSEL_SECOND_EN
        second_valid = out_valid && have_second_q;
        index2_out   = second_valid ? second_idx_q : '0;
`endif
    end

endmodule

// File: tb/tb_fp_argsel_stream.sv
module tb_fp_argsel_stream;

    localparam int IW = 4;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   dataa = '0;
    logic [IW-1:0] index_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] index_out;
    logic [31:0]   data_out;
    logic          none_found;
    logic          busy;
`ifdef FP_ARGSEL_SECOND_EN
    logic [IW-1:0] index2_out;
    logic          second_valid;
`endif

    fp_argsel_stream #(.IDX_W(IW), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .dataa(dataa), .index_in(index_in),
        .out_valid(out_valid), .out_ready(out_ready), .index_out(index_out),
        .data_out(data_out), .none_found(none_found), .busy(busy)
`ifdef FP_ARGSEL_SECOND_EN
        , .index2_out(index2_out), .second_valid(second_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model: collect the frame, pick the winner at the end
    int            m_phase = 0;  // 0 idle, 1 collecting, 2 result pending
    bit            m_mode = 1'b0;
    logic [31:0]   m_data[$];
    logic [IW-1:0] m_idx[$];
    logic [31:0]   r_data;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_idx2;
    bit            r_none;
    bit            r_sv;

    function automatic logic [31:0] key_of(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    function automatic bit nan_of(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    // Earliest extreme non-NaN sample, ignoring position skip.
    function automatic int pick(input bit mn, input int skip);
        int w = -1;
        foreach (m_data[i]) begin
            if (i == skip || nan_of(m_data[i])) continue;
            if (w < 0) w = i;
            else if (mn ? (key_of(m_data[i]) < key_of(m_data[w]))
                        : (key_of(m_data[i]) > key_of(m_data[w]))) w = i;
        end
        return w;
    endfunction

    task automatic finalize();
        int w1;
        int w2;
        w1 = pick(m_mode, -1);
        w2 = (w1 < 0) ? -1 : pick(m_mode, w1);
        r_none <= (w1 < 0);
        r_idx  <= (w1 < 0) ? '0 : m_idx[w1];
        r_data <= (w1 < 0) ? 32'h7FC0_0000 : m_data[w1];
        r_sv   <= (w2 >= 0);
        r_idx2 <= (w2 < 0) ? '0 : m_idx[w2];
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_mode  <= 1'b0;
            m_data.delete();
            m_idx.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_mode  <= mode;
                    m_data.delete();
                    m_idx.delete();
                end
                1: if (in_valid) begin
                    m_data.push_back(dataa);
                    m_idx.push_back(index_in);
                    if (m_data.size() == FL) begin
                        finalize();
                        m_phase <= 2;
                    end
                end
                2: if (out_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("in_ready", in_ready, m_phase == 1);
            chk("out_valid", out_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            if (m_phase == 2) begin
                chk("model_index", index_out, r_idx);
                chk("model_data", data_out, r_data);
                chk("model_none", none_found, r_none);
`ifdef FP_ARGSEL_SECOND_EN
                chk("model_index2", index2_out, r_idx2);
                chk("model_second_valid", second_valid, r_sv);
`endif
            end
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_frame(input bit m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic [IW-1:0] i, input bit gap);
        bit acc = 1'b0;
        int t = 0;
        in_valid = 1'b1;
        dataa    = d;
        index_in = i;
        while (!acc && t < 20) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            t++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        dataa    = 32'hDEAD_BEEF;  // junk while idle-valid must not matter
        index_in = '1;
        if (gap) tick();
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_res(input string tag, input logic [IW-1:0] i, input logic [31:0] d,
                              input bit nf, input logic [IW-1:0] i2, input bit sv);
        chk({tag, "_index"}, index_out, i);
        chk({tag, "_data"}, data_out, d);
        chk({tag, "_none"}, none_found, nf);
`ifdef FP_ARGSEL_SECOND_EN
        chk({tag, "_index2"}, index2_out, i2);
        chk({tag, "_second_valid"}, second_valid, sv);
`endif
    endtask

    // Called at a negedge while DONE; takes the result and checks the return to IDLE.
    task automatic take(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_valid"}, out_valid, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_index", index_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_none", none_found, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

        // Max basic, with latency check
        open_frame(1'b0);
        send(32'h3F80_0000, 4'd1, 1'b0);
        send(32'hC040_0000, 4'd2, 1'b0);
        send(32'h4000_0000, 4'd3, 1'b0);
        send(32'h3F00_0000, 4'd4, 1'b0);
        @(negedge clk);
        chk("max_latency", out_valid, 1'b1);
        expect_res("max", 4'd3, 32'h4000_0000, 1'b0, 4'd1, 1'b1);
        take("max");

        // Min with signed zero and tie
        open_frame(1'b1);
        send(32'h0000_0000, 4'd5, 1'b0);
        send(32'h8000_0000, 4'd6, 1'b0);
        send(32'h8000_0000, 4'd7, 1'b0);
        send(32'h3F80_0000, 4'd8, 1'b0);
        wait_done();
        expect_res("min", 4'd6, 32'h8000_0000, 1'b0, 4'd7, 1'b1);
        take("min");

        // All NaN
        open_frame(1'b0);
        for (int k = 1; k <= 4; k++) send(32'h7FC0_0000, IW'(k), 1'b0);
        wait_done();
        expect_res("allnan", 4'd0, 32'h7FC0_0000, 1'b1, 4'd0, 1'b0);
        take("allnan");

        // Single non-NaN among NaNs
        open_frame(1'b0);
        send(32'h7FC0_0000, 4'd1, 1'b0);
        send(32'h3F80_0000, 4'd2, 1'b0);
        send(32'h7FC0_0000, 4'd3, 1'b0);
        send(32'hFFC0_0000, 4'd4, 1'b0);
        wait_done();
        expect_res("onenum", 4'd2, 32'h3F80_0000, 1'b0, 4'd0, 1'b0);
        take("onenum");

        // Gapped input, infinities / denormal, output backpressure, start during DONE
        open_frame(1'b0);
        send(32'hBF80_0000, 4'd9, 1'b1);
        send(32'h7F80_0000, 4'd10, 1'b1);
        send(32'h0000_0001, 4'd11, 1'b1);
        send(32'hFF80_0000, 4'd12, 1'b0);
        wait_done();
        for (int k = 0; k < 5; k++) begin
            expect_res("hold", 4'd10, 32'h7F80_0000, 1'b0, 4'd11, 1'b1);
            chk("hold_valid", out_valid, 1'b1);
            start = (k == 2);
            @(negedge clk);
        end
        start = 1'b0;
        start = 1'b1;  // coincident with the handshake; must be ignored
        take("hold");
        start = 1'b0;
        @(negedge clk);
        chk("start_ignored_busy", busy, 1'b0);
        chk("start_ignored_ready", in_ready, 1'b0);

        // Async reset mid-frame
        tick();
        open_frame(1'b0);
        send(32'h7F80_0000, 4'd15, 1'b0);
        send(32'h4000_0000, 4'd14, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_index", index_out, 0);
        chk("arst_data", data_out, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        open_frame(1'b1);
        send(32'h4000_0000, 4'd1, 1'b0);
        send(32'h3F00_0000, 4'd2, 1'b0);
        send(32'h3F00_0000, 4'd3, 1'b0);
        send(32'h7F80_0001, 4'd4, 1'b0);
        wait_done();
        expect_res("postrst", 4'd2, 32'h3F00_0000, 1'b0, 4'd3, 1'b1);
        take("postrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
